elf_ram_uploader: RTL and testbench

Responder for the HPS ioctl upload path: the read-back counterpart of the ROM/BIN download path. It streams CosmacELF main RAM to the HPS so the OSD can save a memory image. Uploads start either from a core-side save request or from a host-initiated upload. The block sits between `hps_io` (`ioctl_*` upload signals) and the RAM arbiter. It freezes the 1802 CPU via a hold handshake while the HPS reads bytes.

---
 rtl/elf_io_pkg.sv | 17 +
 rtl/elf_ram_uploader_if.sv | 62 ++++++
 rtl/elf_timeout_cnt.sv | 27 ++
 rtl/elf_ram_uploader.sv | 168 ++++++++++++++++
 tb/tb_elf_ram_uploader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/elf_io_pkg.sv
// Shared types and constants for the CosmacELF HPS I/O blocks.
// Upload FSM states plus default index and RAM geometry.
package elf_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD,
      ST_READY,
      ST_FETCH,
      ST_CAPT
   } upload_state_t;

   localparam logic [7:0] ELF_UPLOAD_INDEX = 8'h01;
   localparam int         ELF_RAM_ADDR_W   = 12;

endpackage

// File: rtl/elf_ram_uploader_if.sv
// Bundle of ioctl upload, CPU hold and RAM read signals.
// master: the uploader itself; slave: HPS/CPU/RAM side.
interface elf_ram_uploader_if #(
   parameter int ADDR_W = 12
);

   logic              save_req;
   logic              ioctl_upload_req;
   logic              ioctl_upload;
   logic [7:0]        ioctl_index;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_din;
   logic              cpu_hold;
   logic              cpu_held;
   logic              ram_rd;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_q;
   logic              busy;
   logic              done;
   logic              err;
   logic              ovf;

   modport master (
      input  save_req,
      input  ioctl_upload,
      input  ioctl_index,
      input  ioctl_rd,
      input  ioctl_addr,
      input  cpu_held,
      input  ram_q,
      output ioctl_upload_req,
      output ioctl_din,
      output cpu_hold,
      output ram_rd,
      output ram_addr,
      output busy,
      output done,
      output err,
      output ovf
   );

   modport slave (
      output save_req,
      output ioctl_upload,
      output ioctl_index,
      output ioctl_rd,
      output ioctl_addr,
      output cpu_held,
      output ram_q,
      input  ioctl_upload_req,
      input  ioctl_din,
      input  cpu_hold,
      input  ram_rd,
      input  ram_addr,
      input  busy,
      input  done,
      input  err,
      input  ovf
   );

endinterface

// File: rtl/elf_timeout_cnt.sv
// Request timeout counter: clear, count while enabled, and
// flag the cycle on which the count steps onto all-ones.
module elf_timeout_cnt #(
   parameter int TIMEOUT_W = 24
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [TIMEOUT_W-1:0] C_ONE  = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] C_LAST = '1 - C_ONE;

   logic [TIMEOUT_W-1:0] r_cnt;

   // Counter register: clear has priority over enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + C_ONE;
   end

   assign o_expire = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/elf_ram_uploader.sv
// Streams CosmacELF RAM to the HPS over the ioctl upload path,
// holding the 1802 while the host reads bytes.
module elf_ram_uploader
   import elf_io_pkg::*;
#(
   parameter int         ADDR_W       = ELF_RAM_ADDR_W,
   parameter logic [7:0] UPLOAD_INDEX = ELF_UPLOAD_INDEX,
   parameter int         TIMEOUT_W    = 24
) (
   input  logic clk,
   input  logic reset_n,
   elf_ram_uploader_if.master bus
);

   upload_state_t     r_state;
   upload_state_t     w_nxt;
   logic              r_up_d;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_din;
   logic              r_req;
   logic              r_hold;
   logic              r_ram_rd;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_ovf;

   logic w_idx_ok;
   logic w_up_rise;
   logic w_oor;
   logic w_abort;
   logic w_timeout;
   logic w_oor_rd;
   logic w_latch;
   logic w_capt;
   logic w_cnt_en;
   logic w_cnt_clr;
   logic w_expire;

   assign w_idx_ok  = (bus.ioctl_index == UPLOAD_INDEX);
   assign w_up_rise = bus.ioctl_upload && !r_up_d;
   assign w_oor     = |bus.ioctl_addr[24:ADDR_W];

   elf_timeout_cnt #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_tmo (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_expire (w_expire)
   );

   // Next-state and per-cycle event decode.
   always_comb begin
      w_nxt     = r_state;
      w_abort   = 1'b0;
      w_timeout = 1'b0;
      w_oor_rd  = 1'b0;
      w_latch   = 1'b0;
      w_capt    = 1'b0;
      w_cnt_en  = 1'b0;
      w_cnt_clr = (r_state != ST_REQ);
      unique case (r_state)
         ST_IDLE: begin
            if (bus.save_req)
               w_nxt = ST_REQ;
            else if (w_up_rise && w_idx_ok)
               w_nxt = ST_HOLD;
         end
         ST_REQ: begin
            w_cnt_en = 1'b1;
            if (bus.ioctl_upload && w_idx_ok) begin
               w_nxt = ST_HOLD;
            end else if (w_expire) begin
               w_nxt     = ST_IDLE;
               w_timeout = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!bus.ioctl_upload) begin
               w_nxt   = ST_IDLE;
               w_abort = 1'b1;
            end else if (bus.cpu_held) begin
               w_nxt = ST_READY;
            end
         end
         ST_READY: begin
            if (!bus.ioctl_upload) begin
               w_nxt   = ST_IDLE;
               w_abort = 1'b1;
            end else if (bus.ioctl_rd) begin
               if (w_oor) begin
                  w_oor_rd = 1'b1;
               end else begin
                  w_nxt   = ST_FETCH;
                  w_latch = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (!bus.ioctl_upload) begin
               w_nxt   = ST_IDLE;
               w_abort = 1'b1;
            end else begin
               w_nxt = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (!bus.ioctl_upload) begin
               w_nxt   = ST_IDLE;
               w_abort = 1'b1;
            end else begin
               w_nxt  = ST_READY;
               w_capt = 1'b1;
            end
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   // State, registered outputs and address/data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_up_d   <= 1'b0;
         r_addr   <= '0;
         r_din    <= 8'hFF;
         r_req    <= 1'b0;
         r_hold   <= 1'b0;
         r_ram_rd <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_up_d   <= bus.ioctl_upload;
         r_req    <= (w_nxt == ST_REQ);
         r_hold   <= w_nxt inside {ST_HOLD, ST_READY, ST_FETCH, ST_CAPT};
         r_ram_rd <= (w_nxt == ST_FETCH);
         r_busy   <= (w_nxt != ST_IDLE);
         r_done   <= w_abort;
         r_err    <= w_timeout;
         if (w_latch)
            r_addr <= bus.ioctl_addr[ADDR_W-1:0];
         if (w_oor_rd)
            r_din <= 8'hFF;
         else if (w_capt)
            r_din <= bus.ram_q;
         if (w_nxt == ST_HOLD && r_state != ST_HOLD)
            r_ovf <= 1'b0;
         else if (w_oor_rd)
            r_ovf <= 1'b1;
      end
   end

   assign bus.ioctl_upload_req = r_req;
   assign bus.ioctl_din        = r_din;
   assign bus.cpu_hold         = r_hold;
   assign bus.ram_rd           = r_ram_rd;
   assign bus.ram_addr         = r_addr;
   assign bus.busy             = r_busy;
   assign bus.done             = r_done;
   assign bus.err              = r_err;
   assign bus.ovf              = r_ovf;

endmodule

// File: tb/tb_elf_ram_uploader.sv
// Directed + randomized bench for elf_ram_uploader with a
// behavioural RAM and a byte-level expectation model.
module tb_elf_ram_uploader;
   import elf_io_pkg::*;

   localparam int AW = ELF_RAM_ADDR_W;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   elf_ram_uploader_if #(.ADDR_W(AW)) bus ();

   elf_ram_uploader #(
      .ADDR_W       (AW),
      .UPLOAD_INDEX (ELF_UPLOAD_INDEX),
      .TIMEOUT_W    (TW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:4095];

   // Synchronous RAM: data one cycle after the read enable.
   always @(posedge clk)
      if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];

   int n_rd = 0;
   int n_done = 0;
   int n_err = 0;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.ram_rd) n_rd++;
      if (bus.done) n_done++;
      if (bus.err) n_err++;
   end

   int checks = 0;
   int errors = 0;
   logic ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_byte(input logic [24:0] a);
      if (a < 25'd4096) return mem[a[11:0]];
      return 8'hFF;
   endfunction

   // One read strobe, checked 3 cycles later; 4-cycle spacing.
   task automatic rd_chk(input logic [24:0] a, input logic [7:0] e);
      int r0;
      bit oor;
      r0 = n_rd;
      oor = (a >= 25'd4096);
      bus.ioctl_addr = a;
      bus.ioctl_rd = 1'b1;
      tick;
      bus.ioctl_rd = 1'b0;
      if (oor) begin
         ovf_m = 1'b1;
         chk("oor_din_c1", bus.ioctl_din, 8'hFF);
      end
      tick;
      tick;
      chk("din", bus.ioctl_din, e);
      chk("ram_rd_cnt", n_rd - r0, oor ? 0 : 1);
      chk("ovf", bus.ovf, ovf_m);
      tick;
   endtask

   task automatic host_start;
      bus.ioctl_index = 8'h01;
      bus.ioctl_upload = 1'b1;
      tick;
      chk("hold_on_start", bus.cpu_hold, 1);
      chk("busy_on_start", bus.busy, 1);
      bus.cpu_held = 1'b1;
      tick;
   endtask

   int d0;
   int n;
   logic [24:0] a;

   initial begin
      bus.save_req = 1'b0;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_index = 8'h00;
      bus.ioctl_rd = 1'b0;
      bus.ioctl_addr = '0;
      bus.cpu_held = 1'b0;

      // Reset state
      tick;
      tick;
      chk("rst_din", bus.ioctl_din, 8'hFF);
      chk("rst_hold", bus.cpu_hold, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req", bus.ioctl_upload_req, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_pulses", {bus.done, bus.err, bus.ram_rd}, 0);
      reset_n = 1'b1;
      tick;

      // Index filter: index 0 is not ours
      bus.ioctl_index = 8'h00;
      bus.ioctl_upload = 1'b1;
      tick;
      bus.ioctl_addr = 25'h0;
      bus.ioctl_rd = 1'b1;
      tick;
      bus.ioctl_rd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("flt_hold", bus.cpu_hold, 0);
         chk("flt_busy", bus.busy, 0);
         tick;
      end
      chk("flt_din", bus.ioctl_din, 8'hFF);
      bus.ioctl_upload = 1'b0;
      tick;

      // Core-initiated save
      mem[0] = 8'h7A;
      bus.save_req = 1'b1;
      tick;
      bus.save_req = 1'b0;
      chk("sv_req_rise", bus.ioctl_upload_req, 1);
      chk("sv_busy", bus.busy, 1);
      tick;
      tick;
      tick;
      chk("sv_req_held", bus.ioctl_upload_req, 1);
      bus.ioctl_index = 8'h01;
      bus.ioctl_upload = 1'b1;
      tick;
      chk("sv_req_drop", bus.ioctl_upload_req, 0);
      chk("sv_hold", bus.cpu_hold, 1);
      tick;
      tick;
      bus.cpu_held = 1'b1;
      tick;
      rd_chk(25'h000, 8'h7A);
      bus.save_req = 1'b1;
      tick;
      bus.save_req = 1'b0;
      chk("sv_ignored", bus.ioctl_upload_req, 0);
      tick;
      d0 = n_done;
      bus.ioctl_upload = 1'b0;
      tick;
      chk("sv_done", bus.done, 1);
      chk("sv_hold_drop", bus.cpu_hold, 0);
      bus.cpu_held = 1'b0;
      tick;
      chk("sv_done_once", n_done - d0, 1);

      // Full image, host-initiated
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h55;
      d0 = n_rd;
      host_start;
      for (int i = 0; i < 4096; i++) begin
         a = 25'(i);
         rd_chk(a, 8'(i & 255) ^ 8'h55);
      end
      chk("img_rd_total", n_rd - d0, 4096);
      d0 = n_done;
      bus.ioctl_upload = 1'b0;
      tick;
      chk("img_done", bus.done, 1);
      chk("img_hold_drop", bus.cpu_hold, 0);
      bus.cpu_held = 1'b0;
      tick;
      tick;
      chk("img_done_once", n_done - d0, 1);

      // Random contents, random and boundary addresses
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[16] = 8'hA5;
      mem[32] = 8'h3C;
      host_start;
      rd_chk(25'h0FFF, model_byte(25'h0FFF));
      rd_chk(25'h1000, model_byte(25'h1000));
      rd_chk(25'h1FFFFFF, model_byte(25'h1FFFFFF));
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0)
            a = 25'($urandom_range(4096, 33554431));
         else
            a = 25'($urandom_range(0, 4095));
         rd_chk(a, model_byte(a));
      end

      // Abort while the fetch is in flight
      rd_chk(25'h010, 8'hA5);
      bus.ioctl_addr = 25'h020;
      bus.ioctl_rd = 1'b1;
      tick;
      bus.ioctl_rd = 1'b0;
      bus.ioctl_upload = 1'b0;
      tick;
      chk("ab_done", bus.done, 1);
      chk("ab_hold", bus.cpu_hold, 0);
      chk("ab_din", bus.ioctl_din, 8'hA5);
      bus.cpu_held = 1'b0;
      tick;
      chk("ab_din_kept", bus.ioctl_din, 8'hA5);
      chk("ab_busy", bus.busy, 0);
      chk("ovf_sticky", bus.ovf, 1);

      // ovf clears on HOLD entry; then async reset in READY
      bus.ioctl_upload = 1'b1;
      tick;
      chk("ovf_clr", bus.ovf, 0);
      ovf_m = 1'b0;
      bus.cpu_held = 1'b1;
      tick;
      rd_chk(25'h020, 8'h3C);
      reset_n = 1'b0;
      #1;
      chk("ar_hold", bus.cpu_hold, 0);
      chk("ar_din", bus.ioctl_din, 8'hFF);
      chk("ar_busy", bus.busy, 0);
      bus.ioctl_upload = 1'b0;
      bus.cpu_held = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;

      // Timeout: host never answers
      d0 = n_err;
      bus.save_req = 1'b1;
      tick;
      bus.save_req = 1'b0;
      n = 0;
      while (bus.ioctl_upload_req && n < 40) begin
         n++;
         tick;
      end
      chk("to_req_cycles", n, (1 << TW) - 1);
      chk("to_err", bus.err, 1);
      tick;
      chk("to_err_once", n_err - d0, 1);
      chk("to_idle", bus.busy, 0);
      chk("to_hold", bus.cpu_hold, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
